// File: rtl/voting_machine_param_if.sv
// Front-panel bundle for the voting machine: officer/button inputs on one
// side, the LED bank and status flags on the other.
interface voting_machine_param_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int TOT_W = CNT_W + IDX_W;

    logic                mode;
    logic                arm;
    logic [NUM_CAND-1:0] button;
    logic [CNT_W-1:0]    led;
    logic                armed;
    logic                vote_ack;
    logic [IDX_W-1:0]    winner;
    logic                tie;
    logic [TOT_W-1:0]    total;
    logic                sat;

    // Panel side: drives buttons and officer controls, watches the display.
    modport master (
        output mode, arm, button,
        input  led, armed, vote_ack, winner, tie, total, sat
    );

    // Machine side.
    modport slave (
        input  mode, arm, button,
        output led, armed, vote_ack, winner, tie, total, sat
    );
endinterface

// File: rtl/voting_machine_param.sv
// Parametrised voting machine: per-button press qualification, an officer-armed
// one-vote-per-voter handshake, saturating per-candidate counters with a
// running total, registered winner/tie result and an LED bank that either
// flashes an acknowledge or shows a selected candidate's count.
module voting_machine_param #(
    parameter int NUM_CAND  = 4,
    parameter int CNT_W     = 8,
    parameter int PRESS_CYC = 10,
    parameter int ACK_CYC   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    voting_machine_param_if.slave  bus
);
    localparam int IDX_W  = $clog2(NUM_CAND);
    localparam int TOT_W  = CNT_W + IDX_W;
    localparam int HOLD_W = $clog2(PRESS_CYC + 1);
    localparam int ACK_W  = $clog2(ACK_CYC + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(PRESS_CYC);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(PRESS_CYC - 1);
    localparam logic [ACK_W-1:0]  ACK_LOAD  = ACK_W'(ACK_CYC);
    localparam logic [CNT_W-1:0]  CNT_FULL  = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // Lowest set index of a one-hot-or-more vector (0 when empty).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CAND-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // A counter at its top value cannot take another vote.
    function automatic logic cnt_full(input logic [CNT_W-1:0] c);
        return (c == CNT_FULL);
    endfunction

    logic [HOLD_W-1:0]   hold_q [NUM_CAND];
    logic [HOLD_W-1:0]   hold_d [NUM_CAND];
    logic [CNT_W-1:0]    cnt_q  [NUM_CAND];
    logic [CNT_W-1:0]    cnt_d  [NUM_CAND];
    logic [NUM_CAND-1:0] valid;
    state_t              state_q, state_d;
    logic [TOT_W-1:0]    total_q, total_d;
    logic                sat_q, sat_d;
    logic                ack_q, ack_d;
    logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
    logic [IDX_W-1:0]    disp_q, disp_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic                tie_q, tie_d;
    logic [CNT_W-1:0]    led_q, led_d;
    logic [CNT_W-1:0]    max_cnt;
    logic [IDX_W-1:0]    sel;
    logic                accept;

    // A vote is taken only while armed and in voting mode; lowest index wins.
    assign sel    = lowest_idx(valid);
    assign accept = (state_q == ARMED) && !bus.mode && (|valid);

    // Press qualifier: count consecutive high cycles, fire once on reaching PRESS_CYC.
    always_comb begin
        for (int i = 0; i < NUM_CAND; i++) begin
            valid[i]  = 1'b0;
            hold_d[i] = '0;
            if (bus.button[i]) begin
                valid[i]  = (hold_q[i] == HOLD_FIRE);
                hold_d[i] = (hold_q[i] == HOLD_MAX) ? hold_q[i] : hold_q[i] + HOLD_W'(1);
            end
        end
    end

    // Arming FSM next state: one arm buys exactly one vote; result mode disarms.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.arm && !bus.mode) state_d = ARMED;
            ARMED:   if (bus.mode || (|valid)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Vote counting: saturated candidates keep their count and flag the loss.
    always_comb begin
        for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = cnt_q[i];
        total_d = total_q;
        sat_d   = sat_q;
        ack_d   = accept;
        if (accept) begin
            if (cnt_full(cnt_q[sel])) begin
                sat_d = 1'b1;
            end else begin
                cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
                total_d    = total_q + TOT_W'(1);
            end
        end
    end

    // Leader search: first strictly larger count wins, equal nonzero maxima mark a tie.
    always_comb begin
        max_cnt = '0;
        win_d   = '0;
        tie_d   = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt_q[i] > max_cnt) begin
                max_cnt = cnt_q[i];
                win_d   = IDX_W'(i);
                tie_d   = 1'b0;
            end else if ((cnt_q[i] == max_cnt) && (max_cnt != '0)) begin
                tie_d = 1'b1;
            end
        end
    end

    // LED source: acknowledge flash window in voting mode, selected count in result mode.
    always_comb begin
        ack_cnt_d = ack_cnt_q;
        if (accept) begin
            ack_cnt_d = ACK_LOAD;
        end else if (ack_cnt_q != '0) begin
            ack_cnt_d = ack_cnt_q - ACK_W'(1);
        end
        disp_d = disp_q;
        if (bus.mode && (|valid)) disp_d = sel;
        if (bus.mode) begin
            led_d = cnt_q[disp_d];
        end else begin
            led_d = (ack_cnt_d != '0) ? CNT_FULL : '0;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                hold_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            state_q   <= IDLE;
            total_q   <= '0;
            sat_q     <= 1'b0;
            ack_q     <= 1'b0;
            ack_cnt_q <= '0;
            disp_q    <= '0;
            win_q     <= '0;
            tie_q     <= 1'b0;
            led_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                hold_q[i] <= hold_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            state_q   <= state_d;
            total_q   <= total_d;
            sat_q     <= sat_d;
            ack_q     <= ack_d;
            ack_cnt_q <= ack_cnt_d;
            disp_q    <= disp_d;
            win_q     <= win_d;
            tie_q     <= tie_d;
            led_q     <= led_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.armed    = (state_q == ARMED);
    assign bus.vote_ack = ack_q;
    assign bus.winner   = win_q;
    assign bus.tie      = tie_q;
    assign bus.total    = total_q;
    assign bus.sat      = sat_q;
endmodule
